// File: rtl/multi_song_reader.sv
// ---------------------------------------------------------------------------
// multi_song_reader
//
// Song sequencer that walks an external note ROM one song region at a time.
// Each ROM word is {note, duration}; a zero duration marks the end of a song.
// Every accepted note is handed to the note player as registered note and
// duration values with a one-cycle new_note pulse. The reader then waits for
// the player's note_done before it fetches the next word.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high
//   play       level: 1 = run, 0 = pause (never truncates a playing note)
//   song       selected song; a change aborts the current song cleanly
//   loop_en    1 = restart the song at its end instead of stopping
//   note_done  pulse from the player: current note finished
//   rom_addr   {cur_song, index}, registered
//   rom_data   {note, duration}, valid one cycle after rom_addr
//   note       current note, registered
//   duration   current duration, registered
//   new_note   one-cycle pulse, note/duration valid
//   song_done  one-cycle pulse at the end of a song
//   cur_song   song currently being read
//   index      current note index within the song
// ---------------------------------------------------------------------------
module multi_song_reader #(
  parameter int SONG_W = 2,
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  input  logic                      loop_en,
  input  logic                      note_done,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  output logic                      song_done,
  output logic [SONG_W-1:0]         cur_song,
  output logic [IDX_W-1:0]          index
);

  typedef enum logic [2:0] {
    S_PAUSED,
    S_FETCH,
    S_DECODE,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_MAX  = '1;

  state_t state;

  // Split of the ROM word as it arrives during DECODE.
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  // note_done is ignored in the cycle that announces the note. Without this,
  // a stale pulse from the previous note could skip the note just issued.
  logic done_accept;
  assign done_accept = (state == S_WAIT_DONE) && note_done && !new_note;

  // End of song: either the zero-duration sentinel or the last slot of the
  // song region finishing. The index never wraps through overflow.
  logic at_end;
  assign at_end = ((state == S_DECODE) && (rom_dur == '0)) ||
                  (done_accept && (index == IDX_MAX));

  logic song_change;
  assign song_change = (song != cur_song);

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values of state, index and cur_song; blocking
  // assignments here would leak updated values into later decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_PAUSED;
      cur_song  <= song;
      index     <= IDX_ZERO;
      rom_addr  <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      // Pulses default low and are raised only in the cycle that needs them.
      new_note  <= 1'b0;
      song_done <= 1'b0;

      if (song_change) begin
        // Abort: any ROM read in flight belongs to the old song and is never
        // decoded because the state restarts at FETCH or PAUSED.
        cur_song <= song;
        index    <= IDX_ZERO;
        note     <= '0;
        duration <= '0;
        if (play) begin
          state    <= S_FETCH;
          rom_addr <= {song, IDX_ZERO};
        end else begin
          state <= S_PAUSED;
        end
      end else if (at_end) begin
        song_done <= 1'b1;
        index     <= IDX_ZERO;
        if (!loop_en) begin
          state <= S_DONE;
        end else if (play) begin
          state    <= S_FETCH;
          rom_addr <= {cur_song, IDX_ZERO};
        end else begin
          state <= S_PAUSED;
        end
      end else begin
        unique case (state)
          S_PAUSED: begin
            if (play) begin
              state    <= S_FETCH;
              rom_addr <= {cur_song, index};
            end
          end

          // The ROM registers rom_addr on this edge; its data is valid
          // throughout DECODE.
          S_FETCH: state <= S_DECODE;

          // A zero duration is taken by at_end above, so the word here is
          // always a real note.
          S_DECODE: begin
            note     <= rom_note;
            duration <= rom_dur;
            new_note <= 1'b1;
            state    <= S_WAIT_DONE;
          end

          // The player is allowed to finish the note even when play is low.
          // Only the next fetch is held back, and it waits in PAUSED.
          S_WAIT_DONE: begin
            if (done_accept) begin
              index <= index + IDX_ONE;
              if (play) begin
                state    <= S_FETCH;
                rom_addr <= {cur_song, index + IDX_ONE};
              end else begin
                state <= S_PAUSED;
              end
            end
          end

          // Idle until reset or a song change. note and duration hold.
          S_DONE: state <= S_DONE;

          default: state <= S_PAUSED;
        endcase
      end
    end
  end

endmodule
